// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, FSM state and opcode width.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpAnd  = 4'd2,
    OpOr   = 4'd3,
    OpNeg  = 4'd4,
    OpNot  = 4'd5,
    OpShr  = 4'd6,
    OpShra = 4'd7,
    OpShl  = 4'd8,
    OpRor  = 4'd9,
    OpRol  = 4'd10,
    OpMul  = 4'd11,
    OpDiv  = 4'd12
  } alu_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StMulIt,
    StDivIt,
    StDone
  } seq_alu_state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply/divide datapath for seq_alu.
//  - MUL: radix-2 Booth, signed x signed, WIDTH iterations.
//  - DIV: restoring division on magnitudes, WIDTH iterations, sign fix-up on the outputs.
//  One WIDTH+1 adder is shared by both algorithms.
// Ports:
//  clk, rst_n          clock, asynchronous active-low reset
//  load                capture operands and clear the iteration counter
//  is_div              at load: 1 = divide, 0 = multiply
//  step                owner FSM is in an iteration state
//  operand_a/operand_b multiplicand/dividend, multiplier/divisor
//  iter_done           WIDTH iterations have completed
//  mul_lo/mul_hi       signed product halves
//  quotient/remainder  sign-corrected quotient and remainder
module seq_alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             iter_done,
  output logic [WIDTH-1:0] mul_lo,
  output logic [WIDTH-1:0] mul_hi,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  // acc is one bit wider than the operands so a MIN_INT multiplicand cannot overflow
  // the Booth partial sum.
  logic [WIDTH:0]   acc_q, m_q;
  logic [WIDTH-1:0] q_q;
  logic             qm1_q, div_q, neg_quo_q, neg_rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_x, add_y, sum, booth_acc;
  logic             add_sub, booth_op;

  always_comb begin
    a_mag = operand_a[WIDTH-1] ? ('0 - operand_a) : operand_a;
    b_mag = operand_b[WIDTH-1] ? ('0 - operand_b) : operand_b;
  end

  // Shared adder: Booth add/subtract of the multiplicand, or restoring trial subtract.
  always_comb begin
    if (div_q) begin
      add_x    = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
      add_sub  = 1'b1;
      booth_op = 1'b0;
    end else begin
      add_x    = acc_q;
      add_sub  = q_q[0] & ~qm1_q;
      booth_op = q_q[0] ^ qm1_q;
    end
    add_y     = add_sub ? ~m_q : m_q;
    sum       = add_x + add_y + {{WIDTH{1'b0}}, add_sub};
    booth_acc = booth_op ? sum : acc_q;
  end

  assign iter_done = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      div_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else if (load) begin
      acc_q     <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      div_q     <= is_div;
      neg_quo_q <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      neg_rem_q <= operand_a[WIDTH-1];
      if (is_div) begin
        m_q <= {1'b0, b_mag};
        q_q <= a_mag;
      end else begin
        m_q <= {operand_a[WIDTH-1], operand_a};
        q_q <= operand_b;
      end
    end else if (step && !iter_done) begin
      cnt_q <= cnt_q + 1'b1;
      if (div_q) begin
        // Negative trial result means restore (keep the shifted remainder).
        acc_q <= sum[WIDTH] ? add_x : sum;
        q_q   <= {q_q[WIDTH-2:0], ~sum[WIDTH]};
      end else begin
        acc_q <= {booth_acc[WIDTH], booth_acc[WIDTH:1]};
        q_q   <= {booth_acc[0], q_q[WIDTH-1:1]};
        qm1_q <= q_q[0];
      end
    end
  end

  assign mul_lo    = q_q;
  assign mul_hi    = acc_q[WIDTH-1:0];
  assign quotient  = neg_quo_q ? ('0 - q_q) : q_q;
  assign remainder = neg_rem_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/done handshake. Single-cycle ops complete one edge after
// acceptance; MUL/DIV run WIDTH iterations in seq_alu_muldiv and complete at edge WIDTH+1.
// Optional macro SEQ_ALU_FLAGS_EN adds the flags[3:0] = {N,Z,C,V} output.
// Ports:
//  clk, rst_n            clock, asynchronous active-low reset
//  start                 launch; sampled only in IDLE
//  opcode                alu_op_t code
//  operand_a, operand_b  operands (b[SHAMT_W-1:0] is the shift amount)
//  busy                  operation in flight
//  done                  one-cycle completion pulse
//  result_lo, result_hi  results, held until the next completion
//  flags                 {N,Z,C,V} (SEQ_ALU_FLAGS_EN only)
//  div_by_zero           sticky until next accepted start
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
`ifdef SEQ_ALU_FLAGS_EN
  output logic [3:0]       flags,
`endif
  output logic             div_by_zero
);

  seq_alu_state_t   state_q;
  alu_op_t          op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_lo_q, result_hi_q;
  logic             busy_q, done_q, dbz_q;

  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     exec_lo;
  logic [2*WIDTH-1:0]   rot_dbl;
  logic                 fin, fin_dbz;
  logic [WIDTH-1:0]     fin_lo, fin_hi;
  logic                 md_load, md_step, md_done;
  logic [WIDTH-1:0]     mul_lo, mul_hi, quotient, remainder;

  assign shamt = b_q[SHAMT_W-1:0];

  // Single-cycle operations.
  always_comb begin
    exec_lo = '0;
    rot_dbl = '0;
    case (op_q)
      OpAdd:   exec_lo = a_q + b_q;
      OpSub:   exec_lo = a_q - b_q;
      OpAnd:   exec_lo = a_q & b_q;
      OpOr:    exec_lo = a_q | b_q;
      OpNeg:   exec_lo = '0 - a_q;
      OpNot:   exec_lo = ~a_q;
      OpShr:   exec_lo = a_q >> shamt;
      OpShra:  exec_lo = $signed(a_q) >>> shamt;
      OpShl:   exec_lo = a_q << shamt;
      OpRor: begin
        rot_dbl = {a_q, a_q} >> shamt;
        exec_lo = rot_dbl[WIDTH-1:0];
      end
      OpRol: begin
        rot_dbl = {a_q, a_q} << shamt;
        exec_lo = rot_dbl[2*WIDTH-1:WIDTH];
      end
      default: exec_lo = '0;
    endcase
  end

  // Completion-edge values; fin marks the edge that moves to StDone.
  always_comb begin
    fin     = 1'b0;
    fin_lo  = exec_lo;
    fin_hi  = result_hi_q;
    fin_dbz = 1'b0;
    case (state_q)
      StExec: begin
        fin = 1'b1;
        // Only a zero-divisor DIV reaches StExec.
        if (op_q == OpDiv) begin
          fin_lo  = '1;
          fin_hi  = a_q;
          fin_dbz = 1'b1;
        end
      end
      StMulIt: begin
        fin    = md_done;
        fin_lo = mul_lo;
        fin_hi = mul_hi;
      end
      StDivIt: begin
        fin    = md_done;
        fin_lo = quotient;
        fin_hi = remainder;
      end
      default: ;
    endcase
  end

  assign md_load = (state_q == StIdle) && start &&
                   ((opcode == OpMul) || ((opcode == OpDiv) && (operand_b != '0)));
  assign md_step = (state_q == StMulIt) || (state_q == StDivIt);

  seq_alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (md_load),
    .is_div    (opcode == OpDiv),
    .step      (md_step),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .iter_done (md_done),
    .mul_lo    (mul_lo),
    .mul_hi    (mul_hi),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= OpAdd;
      a_q         <= '0;
      b_q         <= '0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q   <= alu_op_t'(opcode);
            a_q    <= operand_a;
            b_q    <= operand_b;
            busy_q <= 1'b1;
            dbz_q  <= 1'b0;
            if (opcode == OpMul) begin
              state_q <= StMulIt;
            end else if ((opcode == OpDiv) && (operand_b != '0)) begin
              state_q <= StDivIt;
            end else begin
              state_q <= StExec;
            end
          end
        end
        StExec, StMulIt, StDivIt: begin
          if (fin) begin
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (fin) begin
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
        result_lo_q <= fin_lo;
        result_hi_q <= fin_hi;
        dbz_q       <= fin_dbz;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = result_lo_q;
  assign result_hi   = result_hi_q;
  assign div_by_zero = dbz_q;

`ifdef SEQ_ALU_FLAGS_EN
  logic [3:0]     flags_q;
  logic           flag_c, flag_v;
  logic [WIDTH:0] add_w, sub_w, shl_w, shr_w;

  always_comb begin
    add_w  = {1'b0, a_q} + {1'b0, b_q};
    sub_w  = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    // Extra bit catches the last bit shifted out; stays 0 for amount 0.
    shl_w  = {1'b0, a_q} << shamt;
    shr_w  = {a_q, 1'b0} >> shamt;
    flag_c = 1'b0;
    flag_v = 1'b0;
    if (state_q == StExec) begin
      case (op_q)
        OpAdd: begin
          flag_c = add_w[WIDTH];
          flag_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
        end
        OpSub: begin
          flag_c = sub_w[WIDTH];
          flag_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
        end
        OpNeg:         flag_v = a_q[WIDTH-1] & exec_lo[WIDTH-1];
        OpShr, OpShra: flag_c = shr_w[0];
        OpShl:         flag_c = shl_w[WIDTH];
        default: ;
      endcase
    end else if (state_q == StMulIt) begin
      flag_v = (mul_hi != {WIDTH{mul_lo[WIDTH-1]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (fin) begin
      flags_q <= {fin_lo[WIDTH-1], (fin_lo == '0), flag_c, flag_v};
    end
  end

  assign flags = flags_q;
`endif

endmodule
